// File: rtl/ddot_issue.sv
// ddot_issue: buffers one x/y vector pair, streams it as 4-lane beats to the
// dot-product unit and collects the returning partial sums in a result FIFO.
// Optional drain watchdog and sticky tmo flag: define DDOT_ISSUE_TMO_EN.
module ddot_issue #(
    parameter int DEPTH = 16,
    parameter int TMO   = 64,
    localparam int NB   = DEPTH / 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(NB) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_x_i,
    input  logic [31:0]   wr_y_i,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          tmo_o,
    output logic          ready_o,
    output logic [31:0]   x0_o,
    output logic [31:0]   x1_o,
    output logic [31:0]   x2_o,
    output logic [31:0]   x3_o,
    output logic [31:0]   y0_o,
    output logic [31:0]   y1_o,
    output logic [31:0]   y2_o,
    output logic [31:0]   y3_o,
    input  logic          vld_i,
    input  logic [31:0]   z_i,
    input  logic          res_rd_i,
    output logic [31:0]   res_data_o,
    output logic          res_empty_o
);

    localparam int PW = (NB > 1) ? $clog2(NB) : 1;

    if ((DEPTH % 4) != 0 || DEPTH < 4 || TMO < 1) begin : g_bad_cfg
        $error("ddot_issue: DEPTH must be a multiple of 4 (>=4), TMO >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [LW-1:0] ret_q, ret_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [31:0]   x_q [4];
    logic [31:0]   y_q [4];
    logic [31:0]   x_d [4];
    logic [31:0]   y_d [4];
    logic [31:0]   lane_x [4];
    logic [31:0]   lane_y [4];

    logic [31:0]   xbuf_q [DEPTH];
    logic [31:0]   ybuf_q [DEPTH];

    logic [31:0]   fifo_q [NB];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [LW-1:0] cnt_q, cnt_d;

    logic          accept;
    logic          count;
    logic          pop;
    logic [LW-1:0] sel_beat;

`ifdef DDOT_ISSUE_TMO_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;
`endif

    // A run needs an empty FIFO so it can never overflow; stray returns are dropped.
    assign accept   = start_i && (state_q == IDLE) && (len_i != '0)
                    && (len_i <= LW'(NB)) && (cnt_q == '0);
    assign count    = vld_i && (state_q != IDLE) && (ret_q < len_q);
    assign pop      = res_rd_i && (cnt_q != '0);
    assign sel_beat = (state_q == IDLE) ? '0 : beat_q;

    // Fetch the four element pairs of the beat about to be presented.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_x[k] = xbuf_q[AW'(int'(sel_beat) * 4 + k)];
            lane_y[k] = ybuf_q[AW'(int'(sel_beat) * 4 + k)];
            x_d[k]    = ready_d ? lane_x[k] : '0;
            y_d[k]    = ready_d ? lane_y[k] : '0;
        end
    end

    // Run sequencing: issue len beats, then wait for all returns and pulse done.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        ret_d   = ret_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef DDOT_ISSUE_TMO_EN
        tcnt_d  = tcnt_q;
        tmo_d   = tmo_q;
`endif
        if (count) begin
            ret_d = ret_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d   = len_i;
                    beat_d  = LW'(1);
                    ret_d   = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
`ifdef DDOT_ISSUE_TMO_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            ISSUE: begin
                if (beat_q < len_q) begin
                    ready_d = 1'b1;
                    beat_d  = beat_q + 1'b1;
                end else begin
                    state_d = DRAIN;
                    done_d  = (ret_q == len_q);
`ifdef DDOT_ISSUE_TMO_EN
                    tcnt_d  = '0;
`endif
                end
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (ret_q == len_q) begin
                    done_d = 1'b1;
                end else begin
`ifdef DDOT_ISSUE_TMO_EN
                    if (count) begin
                        tcnt_d = '0;
                    end else if (tcnt_q == TW'(TMO - 1)) begin
                        tmo_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result FIFO pointers; push and pop in one cycle leave the count unchanged.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (count) begin
            wp_d = (wp_q == PW'(NB - 1)) ? '0 : wp_q + 1'b1;
        end
        if (pop) begin
            rp_d = (rp_q == PW'(NB - 1)) ? '0 : rp_q + 1'b1;
        end
        case ({count, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control, lane and FIFO pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            ret_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < 4; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            ret_q   <= ret_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < 4; k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
            end
        end
    end

`ifdef DDOT_ISSUE_TMO_EN
    // Drain watchdog state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end
    assign tmo_o = tmo_q;
`else
    assign tmo_o = 1'b0;
`endif

    // Vector buffer, writable only while idle.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && (state_q == IDLE) && (int'(wr_addr_i) < DEPTH)) begin
            xbuf_q[wr_addr_i] <= wr_x_i;
            ybuf_q[wr_addr_i] <= wr_y_i;
        end
    end

    // Result FIFO storage.
    always_ff @(posedge clk_i) begin
        if (count) begin
            fifo_q[wp_q] <= z_i;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ready_o     = ready_q;
    assign x0_o        = x_q[0];
    assign x1_o        = x_q[1];
    assign x2_o        = x_q[2];
    assign x3_o        = x_q[3];
    assign y0_o        = y_q[0];
    assign y1_o        = y_q[1];
    assign y2_o        = y_q[2];
    assign y3_o        = y_q[3];
    assign res_empty_o = (cnt_q == '0);
    assign res_data_o  = (cnt_q == '0) ? '0 : fifo_q[rp_q];

endmodule

// File: tb/tb_ddot_issue.sv
// tb_ddot_issue: drives ddot_issue against a behavioural dot-product unit
// and checks popped results against a queue of expected partial sums.
module tb_ddot_issue;

    localparam int DEPTH = 16;
    localparam int NB    = 4;
    localparam int TMO   = 64;
    localparam int LAT   = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wr_en_i;
    logic [3:0]  wr_addr_i;
    logic [31:0] wr_x_i, wr_y_i;
    logic        start_i;
    logic [2:0]  len_i;
    logic        busy_o, done_o, tmo_o, ready_o;
    logic [31:0] x0_o, x1_o, x2_o, x3_o;
    logic [31:0] y0_o, y1_o, y2_o, y3_o;
    logic        vld_i = 1'b0;
    logic [31:0] z_i = '0;
    logic        res_rd_i;
    logic [31:0] res_data_o;
    logic        res_empty_o;

    ddot_issue #(.DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_x_i(wr_x_i), .wr_y_i(wr_y_i),
        .start_i(start_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .tmo_o(tmo_o), .ready_o(ready_o),
        .x0_o(x0_o), .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o),
        .y0_o(y0_o), .y1_o(y1_o), .y2_o(y2_o), .y3_o(y3_o),
        .vld_i(vld_i), .z_i(z_i),
        .res_rd_i(res_rd_i), .res_data_o(res_data_o), .res_empty_o(res_empty_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Integer-valued single-precision helpers for the stand-in unit and model.
    function automatic int f2i(input logic [31:0] f);
        int e;
        int m;
        e = int'(f[30:23]);
        m = int'({1'b1, f[22:0]});
        if (f[30:0] == 31'h0 || e < 127) return 0;
        if (e >= 150) return m <<< (e - 150);
        return m >>> (150 - e);
    endfunction

    function automatic logic [31:0] i2f(input int n);
        int p;
        logic [7:0] e;
        logic [31:0] m;
        if (n <= 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if (n[i]) p = i;
        e = 8'(127 + p);
        m = 32'(n) << (23 - p);
        return {1'b0, e, m[22:0]};
    endfunction

    logic [31:0] xm [DEPTH];
    logic [31:0] ym [DEPTH];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] exp_beat(input int b);
        int s = 0;
        for (int k = 0; k < 4; k++) s += f2i(xm[4*b+k]) * f2i(ym[4*b+k]);
        return i2f(s);
    endfunction

    // Behavioural dot-product unit with fixed latency and optional drop.
    logic        pv [LAT] = '{default: 1'b0};
    logic [31:0] pz [LAT] = '{default: 32'h0};
    int          nbeat = 0;
    int          sup_after = 1000;
    logic        stray = 1'b0;

    always @(negedge clk_i) begin
        vld_i = pv[LAT-1] || stray;
        z_i   = stray ? 32'hdead_beef : pz[LAT-1];
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pz[i] = pz[i-1];
        end
        pv[0] = ready_o && (nbeat < sup_after);
        pz[0] = i2f(f2i(x0_o) * f2i(y0_o) + f2i(x1_o) * f2i(y1_o)
                  + f2i(x2_o) * f2i(y2_o) + f2i(x3_o) * f2i(y3_o));
        if (!busy_o) nbeat = 0;
        else if (ready_o) nbeat++;
    end

    // Lane and handshake monitor, sampled just after each rising edge.
    int ready_cnt = 0;
    int done_cnt  = 0;
    int lane_beat = 0;
    int cyc       = 0;
    int done_cyc  = 0;

    always @(posedge clk_i) begin
        #1;
        cyc++;
        if (ready_o) begin
            if (lane_beat < NB) begin
                chk("lane_x0", x0_o, xm[4*lane_beat+0]);
                chk("lane_x1", x1_o, xm[4*lane_beat+1]);
                chk("lane_x2", x2_o, xm[4*lane_beat+2]);
                chk("lane_x3", x3_o, xm[4*lane_beat+3]);
                chk("lane_y0", y0_o, ym[4*lane_beat+0]);
                chk("lane_y1", y1_o, ym[4*lane_beat+1]);
                chk("lane_y2", y2_o, ym[4*lane_beat+2]);
                chk("lane_y3", y3_o, ym[4*lane_beat+3]);
            end else begin
                chk("beat_range", 32'(lane_beat), 32'(NB - 1));
            end
            lane_beat++;
            ready_cnt++;
        end else begin
            chk("lane_idle", x0_o | x1_o | x2_o | x3_o | y0_o | y1_o | y2_o | y3_o, 32'h0);
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic wr_model();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk_i);
            wr_en_i   = 1'b1;
            wr_addr_i = 4'(i);
            wr_x_i    = xm[i];
            wr_y_i    = ym[i];
        end
        @(negedge clk_i);
        wr_en_i = 1'b0;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < DEPTH; i++) begin
            xm[i] = v;
            ym[i] = v;
        end
    endtask

    task automatic start_run(input int len, input bit acc, input int npush);
        @(negedge clk_i);
        lane_beat = 0;
        ready_cnt = 0;
        done_cnt  = 0;
        if (acc) for (int b = 0; b < npush; b++) exp_q.push_back(exp_beat(b));
        start_i = 1'b1;
        len_i   = 3'(len);
        @(negedge clk_i);
        start_i = 1'b0;
        chk(acc ? "busy_on" : "busy_rej", 32'(busy_o), 32'(acc));
    endtask

    task automatic drain();
        int i = 0;
        logic [31:0] e;
        while (exp_q.size() > 0 && i < 64) begin
            e = exp_q.pop_front();
            chk("res_empty", 32'(res_empty_o), 32'h0);
            chk("res_data", res_data_o, e);
            res_rd_i = 1'b1;
            @(negedge clk_i);
            i++;
        end
        res_rd_i = 1'b0;
        chk("res_empty_end", 32'(res_empty_o), 32'h1);
        chk("res_data_end", res_data_o, 32'h0);
    endtask

    task automatic finish_run(input int len, input bit do_drain);
        int i = 0;
        while (busy_o && i < 200) begin
            @(negedge clk_i);
            i++;
        end
        chk("busy_off", 32'(busy_o), 32'h0);
        @(negedge clk_i);
        chk("ready_cnt", 32'(ready_cnt), 32'(len));
        chk("done_cnt", 32'(done_cnt), 32'h1);
        if (do_drain) drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "tb_ddot_issue watchdog");
    end

    initial begin
        int s;
        rst_ni    = 1'b0;
        wr_en_i   = 1'b0;
        wr_addr_i = '0;
        wr_x_i    = '0;
        wr_y_i    = '0;
        start_i   = 1'b0;
        len_i     = '0;
        res_rd_i  = 1'b0;
        fill(32'h0);
        repeat (3) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_ready", 32'(ready_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_tmo", 32'(tmo_o), 32'h0);
        chk("rst_empty", 32'(res_empty_o), 32'h1);
        chk("rst_data", res_data_o, 32'h0);
        rst_ni = 1'b1;

        // Single beat of ones.
        fill(32'h4040_0000);
        for (int i = 0; i < 4; i++) begin
            xm[i] = 32'h3f80_0000;
            ym[i] = 32'h3f80_0000;
        end
        wr_model();
        start_run(1, 1, 1);
        finish_run(1, 1);

        // Full run of twos.
        fill(32'h4000_0000);
        wr_model();
        start_run(4, 1, 4);
        finish_run(4, 1);

        // Distinct per-lane values expose lane mapping.
        for (int i = 0; i < DEPTH; i++) begin
            xm[i] = i2f(i + 1);
            ym[i] = i2f(i % 3 + 1);
        end
        wr_model();
        start_run(3, 1, 3);
        finish_run(3, 1);
        start_run(2, 1, 2);
        finish_run(2, 1);

        // Rejected starts.
        start_run(0, 0, 0);
        start_run(5, 0, 0);
        start_run(1, 1, 1);
        finish_run(1, 0);
        start_run(1, 0, 0);
        repeat (3) @(negedge clk_i);
        chk("ready_rej", 32'(ready_cnt), 32'h0);
        chk("busy_rej_hold", 32'(busy_o), 32'h0);
        drain();

        // Writes while busy are ignored.
        fill(32'h3f80_0000);
        wr_model();
        start_run(4, 1, 4);
        wr_en_i   = 1'b1;
        wr_addr_i = 4'h0;
        wr_x_i    = 32'h0;
        wr_y_i    = 32'h0;
        @(negedge clk_i);
        wr_en_i = 1'b0;
        finish_run(4, 1);
        start_run(1, 1, 1);
        finish_run(1, 1);

        // Stray return while idle.
        @(posedge clk_i);
        #2 stray = 1'b1;
        @(posedge clk_i);
        #2 stray = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("stray_empty", 32'(res_empty_o), 32'h1);

        // Reset during beat 2.
        start_run(4, 1, 4);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("mrst_ready", 32'(ready_o), 32'h0);
        chk("mrst_x0", x0_o, 32'h0);
        chk("mrst_y3", y3_o, 32'h0);
        chk("mrst_busy", 32'(busy_o), 32'h0);
        chk("mrst_empty", 32'(res_empty_o), 32'h1);
        exp_q.delete();
        done_cnt = 0;
        repeat (4) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (6) @(negedge clk_i);
        chk("mrst_nodone", 32'(done_cnt), 32'h0);
        chk("mrst_idle", 32'(busy_o), 32'h0);
        chk("mrst_empty2", 32'(res_empty_o), 32'h1);

        // Recovery after reset.
        wr_model();
        start_run(2, 1, 2);
        finish_run(2, 1);

`ifdef DDOT_ISSUE_TMO_EN
        // Drain watchdog: only two of four results come back.
        sup_after = 2;
        start_run(4, 1, 2);
        s = cyc;
        finish_run(4, 0);
        chk("tmo_flag", 32'(tmo_o), 32'h1);
        chk("tmo_lat", 32'((done_cyc - s) >= TMO && (done_cyc - s) <= TMO + 8), 32'h1);
        drain();
        sup_after = 1000;
        start_run(1, 1, 1);
        chk("tmo_clr", 32'(tmo_o), 32'h0);
        finish_run(1, 1);
`else
        s = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ddot_issue.md
# ddot_issue

Initiator-side sequencer for the 4-lane floating-point dot-product unit (`basic_ddot`). It holds one x/y vector pair in a local buffer and streams it to the unit as 4-wide beats with `ready` asserted. It counts the returning `vld`/`z` partial results, stores them in a result FIFO, and pulses `done` when every issued beat has returned. It sits between the host load interface and `basic_ddot`, which is instantiated alongside it.

## Interface
- `DEPTH`, 16: buffer depth in 32-bit elements per vector. Must be a multiple of 4 and at least 4.
- `TMO`, 64: drain watchdog limit in cycles. Used only when `DDOT_ISSUE_TMO_EN` is defined.
- `NB`: derived localparam, equal to `DEPTH/4`. It is the maximum number of beats per run and the FIFO depth.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write one element pair into the buffer.
- `wr_addr` in clog2(DEPTH): element index for the write.
- `wr_x`, `wr_y` in 32: IEEE-754 single-precision x and y elements.
- `start` in 1: begin a run.
- `len` in clog2(NB)+1: number of beats in the run, valid range 1..NB.
- `busy` out 1: high while the FSM is not IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `tmo` out 1: sticky timeout flag, cleared by an accepted `start`. Present only with the macro; otherwise tied to 0.
- `ready` out 1: beat valid toward `basic_ddot`.
- `x0..x3`, `y0..y3` out 32: lane operands.
- `vld` in 1: result valid from `basic_ddot`.
- `z` in 32: partial dot product from `basic_ddot`.
- `res_rd` in 1: pop the result FIFO.
- `res_data` out 32: head of the FIFO, show-ahead.
- `res_empty` out 1: FIFO empty.

## Operation
- **Buffer writes.** Writes are honoured only in IDLE. `wr_en` in any other state is ignored.
- **Lane mapping.** Beat b drives `x_k = xbuf[4b+k]` and `y_k = ybuf[4b+k]` for k = 0..3.
- **FSM: IDLE -> ISSUE -> DRAIN -> IDLE.**
  - **IDLE.** `start` is accepted only when `1 <= len <= NB` and `res_empty=1`. On accept, latch `len`, clear the beat counter and return counter, and go to ISSUE. Any other `start` is ignored with no state change.
  - **ISSUE.** `ready=1` for exactly `len` consecutive cycles, with the beat counter advancing 0..len-1. After the last beat, go to DRAIN.
  - **DRAIN.** Wait until the return counter equals `len`. Then assert `done` for one cycle and go to IDLE.
- **Returns.**
  - `vld` is counted in both ISSUE and DRAIN.
  - Each counted `vld` pushes `z` into the FIFO.
  - `vld` in IDLE is ignored: no push and no count.
  - `vld` beyond `len` within a run is ignored.
- **Result FIFO.**
  - Depth is NB. Overflow cannot occur, because a run requires an empty FIFO and `len <= NB`.
  - `res_rd` while empty is ignored.
  - A push and a pop in the same cycle are both performed.
- **Lanes outside a beat.** When `ready=0`, all lane outputs are driven to 32'h0.
- **Reset.** Asynchronous assertion at any point, including mid-run, returns the block to IDLE. Outputs go to `ready=0`, lanes 0, `busy=0`, `done=0`, `tmo=0`, `res_empty=1`, `res_data=0`.
  - The FIFO is emptied and both counters are cleared.
  - Buffer contents are don't-care after reset.

## Timing
- All outputs are registered.
- `start` sampled at edge T produces `ready=1` and beat 0 lanes from edge T+1 through T+len, and `busy=1` from T+1.
- The last counted `vld`, sampled at edge R, produces `done=1` for the cycle after R, then `busy=0` and IDLE at R+2.
- If the last return arrives during ISSUE, `done` follows the last beat by one cycle.
- A pushed `z` is visible on `res_data` with `res_empty=0` one cycle after the `vld` edge.
- A new `start` is accepted in the first IDLE cycle.

## Configuration
- **`DDOT_ISSUE_TMO_EN` defined.**
  - In DRAIN, a counter counts cycles since the last counted `vld`, or since DRAIN entry.
  - On reaching `TMO`, set `tmo=1`, pulse `done`, and go to IDLE. Results already pushed remain in the FIFO.
- **Undefined.** DRAIN waits indefinitely, `tmo` is tied to 0, and the watchdog logic is absent.

## Test plan
- **Single beat.**
  - Stimulus: load elements 0..3 with x=y=32'h3f800000, then `start` with `len=1`.
  - Response: `ready` high for 1 cycle, one `done` pulse, FIFO yields 32'h40800000, then `res_empty=1`.
- **Full run.**
  - Stimulus: load all 16 elements with 32'h40000000, then `start` with `len=4`.
  - Response: 4 back-to-back `ready` cycles, 4 results of 32'h41800000 popped in order, one `done` pulse.
- **Rejected starts.**
  - Stimulus: `start` with `len=0`, then `len=5`, then a valid `len` while the FIFO is non-empty.
  - Response: all three are ignored, with `busy` staying 0.
- **Writes while busy.**
  - Stimulus: `wr_en` to element 0 with 32'h0 during ISSUE.
  - Response: the buffer is unchanged, and a later run with `len=1` still returns 32'h40800000.
- **Reset mid-run.**
  - Stimulus: assert `rst` low during beat 2 of a `len=4` run.
  - Response: `ready=0`, lanes 0, `busy=0`, `res_empty=1` immediately; no `done` pulse.
- **Timeout (macro defined).**
  - Stimulus: bench suppresses `vld` after 2 returns in a `len=4` run.
  - Response: `done` and `tmo=1` follow 64 cycles after the second return, and the FIFO holds 2 entries.
